// File: rtl/core_if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package core_if_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT    = 64'h0;
  localparam int          QUEUE_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc4;
  } IF_regs_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc4;
  } fetch_entry_t;

  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/core_if_fetch_fifo.sv
// Small synchronous FIFO for fetched instructions; clear wins over push/pop.
module fetch_fifo #(
  parameter type T          = logic [7:0],
  parameter int  DEPTH      = 4,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output T              head
);

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/core_if.sv
// Instruction-fetch stage: PC ownership, credit-limited imem requests,
// response queueing, redirect handling and the IF_regs pipeline register.
module core_if
  import core_if_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  output IF_regs_t    IF_regs
);

  localparam int            CW      = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  logic [63:0]   pc;
  logic [63:0]   resp_pc;
  logic [63:0]   redirect_aligned;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_count;
  logic [CW-1:0] live;
  logic [CW:0]   occupancy;
  logic          deq;
  logic          accept;
  logic          enq;
  logic          drop_resp;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
  // imem_req_addr is pc and only moves on a transfer or a redirect, so it is stable
  // while a request waits. Responses have no back-pressure: imem_resp_valid alone
  // delivers one in-order word.
  always_comb begin
    redirect_aligned = word_align(redirect_pc);
    deq              = !stall && (q_count != '0);
    live             = outstanding - drop_cnt;
    occupancy        = {1'b0, q_count} + {1'b0, live} - {{CW{1'b0}}, deq};
    imem_req_valid   = reset && !redirect_valid && (outstanding < DEPTH_C) &&
                       (occupancy < {1'b0, DEPTH_C});
    accept           = imem_req_valid && imem_req_ready;
    drop_resp        = imem_resp_valid && (drop_cnt != '0);
    enq              = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
    outstanding_next = outstanding + CW'(accept) - CW'(imem_resp_valid);
    push_entry.inst  = imem_resp_inst;
    push_entry.pc4   = resp_pc + 64'd4;
  end

  assign imem_req_addr = pc;

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (enq),
    .push_data (push_entry),
    .pop       (deq && !redirect_valid),
    .count     (q_count),
    .head      (head)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      IF_regs     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        // Everything still in flight, including any response landing now, is stale.
        pc       <= redirect_aligned;
        resp_pc  <= redirect_aligned;
        drop_cnt <= outstanding_next;
        IF_regs  <= '0;
      end else begin
        if (accept)    pc       <= pc + 64'd4;
        if (enq)       resp_pc  <= resp_pc + 64'd4;
        if (drop_resp) drop_cnt <= drop_cnt - CW'(1);
        if (!stall) begin
          if (q_count != '0) begin
            IF_regs.inst <= head.inst;
            IF_regs.pc4  <= head.pc4;
          end else begin
            IF_regs <= '0;
          end
        end
      end
    end
  end

  resp_without_request: assert property (@(posedge clock) disable iff (!reset)
    imem_resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_core_if.sv
// Self-checking bench for core_if: queue-level reference model, in-order memory model
// with variable latency, directed scenarios and a randomized phase.
module tb_core_if;
  import core_if_pkg::*;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_inst = '0;
  IF_regs_t    IF_regs;

  core_if #(.RESET_PC(64'h0), .QUEUE_DEPTH(D)) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .IF_regs         (IF_regs)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference model state
  typedef struct {
    int          due;
    logic [31:0] inst;
  } pend_t;

  pend_t       pending[$];
  logic [95:0] exp_q[$];
  logic [63:0] m_pc;
  logic [63:0] m_rp;
  int          m_out;
  int          m_drop;
  logic [95:0] m_ifr;
  bit          m_rv;
  int          cyc;
  int          last_due;
  int          lat_min = 1;
  int          lat_max = 1;

  int          checks = 0;
  int          passes = 0;

  logic        obs_rv;
  logic [63:0] obs_addr;
  logic [95:0] obs_ifr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit model_rv();
    int deq;
    deq = (!stall && exp_q.size() > 0) ? 1 : 0;
    return !redirect_valid && (m_out < D) && ((exp_q.size() + m_out - m_drop - deq) < D);
  endfunction

  task automatic model_reset();
    pending.delete();
    exp_q.delete();
    m_pc = 64'h0; m_rp = 64'h0; m_out = 0; m_drop = 0; m_ifr = '0;
    last_due = 0;
  endtask

  task automatic model_update();
    bit acc;
    bit resp;
    int due;
    acc  = m_rv && imem_req_ready;
    resp = imem_resp_valid;
    cyc++;
    if (resp) void'(pending.pop_front());
    if (acc) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pending.push_back('{due, mem_word(m_pc)});
    end
    if (redirect_valid) begin
      exp_q.delete();
      m_ifr  = '0;
      m_pc   = redirect_pc & ~64'h3;
      m_rp   = redirect_pc & ~64'h3;
      m_out  = m_out - int'(resp);
      m_drop = m_out;
    end else begin
      if (!stall) begin
        if (exp_q.size() > 0) m_ifr = exp_q.pop_front();
        else m_ifr = '0;
      end
      if (resp) begin
        if (m_drop > 0) m_drop--;
        else begin
          exp_q.push_back({imem_resp_inst, m_rp + 64'd4});
          m_rp = m_rp + 64'd4;
        end
      end
      if (acc) m_pc = m_pc + 64'd4;
      m_out = m_out + int'(acc) - int'(resp);
    end
  endtask

  // driver: one full cycle, inputs at negedge, compare, then model at posedge
  task automatic step(input bit s, input bit r, input logic [63:0] rpc, input bit rdy);
    @(negedge clock);
    stall = s; redirect_valid = r; redirect_pc = rpc; imem_req_ready = rdy;
    if (pending.size() > 0 && pending[0].due <= cyc + 1) begin
      imem_resp_valid = 1'b1;
      imem_resp_inst  = pending[0].inst;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_inst  = $urandom;
    end
    m_rv = model_rv();
    #1;
    obs_rv = imem_req_valid; obs_addr = imem_req_addr; obs_ifr = IF_regs;
    chk("req_valid", {95'd0, obs_rv}, {95'd0, m_rv});
    chk("req_addr", {32'd0, obs_addr}, {32'd0, m_pc});
    chk("if_regs", obs_ifr, m_ifr);
    @(posedge clock);
    model_update();
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_valid", {95'd0, imem_req_valid}, 96'd0);
    chk("rst_if_regs", IF_regs, 96'd0);
    chk("rst_req_addr", {32'd0, imem_req_addr}, 96'd0);
    #1 reset = 1'b1;
  endtask

  logic [63:0] seen_pc4 [1:6];
  logic [63:0] seen_addr[1:6];
  logic [63:0] first_pc4;

  initial begin
    cyc = 0;
    // 1: stream after reset, latency 1
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 64'h0, 1);
      seen_pc4[k]  = obs_ifr[63:0];
      seen_addr[k] = obs_addr;
      if (k == 4) chk("t1_inst0", {64'd0, obs_ifr[95:64]}, 96'h1357_9BDF);
    end
    chk("t1_addr1", {32'd0, seen_addr[1]}, 96'h0);
    chk("t1_addr2", {32'd0, seen_addr[2]}, 96'h4);
    chk("t1_addr3", {32'd0, seen_addr[3]}, 96'h8);
    chk("t1_pc4_e2", {32'd0, seen_pc4[3]}, 96'h0);
    chk("t1_pc4_e3", {32'd0, seen_pc4[4]}, 96'h4);
    chk("t1_pc4_e4", {32'd0, seen_pc4[5]}, 96'h8);
    chk("t1_pc4_e5", {32'd0, seen_pc4[6]}, 96'hC);

    // 2: three stall cycles fill the queue and throttle requests
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 64'h0, 1);
      chk("t2_held", {32'd0, obs_ifr[63:0]}, 96'h10);
      if (k == 3) chk("t2_req_throttled", {95'd0, obs_rv}, 96'd0);
    end
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 64'h0, 1);
      if (k == 2) chk("t2_resume0", {32'd0, obs_ifr[63:0]}, 96'h14);
      if (k == 3) chk("t2_resume1", {32'd0, obs_ifr[63:0]}, 96'h18);
    end

    // 3: latency 3, two in flight, redirect to unaligned target
    do_reset();
    lat_min = 3; lat_max = 3;
    step(0, 0, 64'h0, 1);
    step(0, 0, 64'h0, 1);
    step(0, 1, 64'h1002, 1);
    step(0, 0, 64'h0, 1);
    chk("t3_new_addr", {32'd0, obs_addr}, 96'h1000);
    chk("t3_new_valid", {95'd0, obs_rv}, 96'd1);
    first_pc4 = '0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 64'h0, 1);
      if (first_pc4 == 64'h0 && obs_ifr[63:0] != 64'h0) first_pc4 = obs_ifr[63:0];
    end
    chk("t3_first_pc4", {32'd0, first_pc4}, 96'h1004);

    // 4: ready low for five cycles
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (6) step(0, 0, 64'h0, 1);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 64'h0, 0);
      chk("t4_addr_stable", {32'd0, obs_addr}, 96'h18);
      if (k == 5) chk("t4_bubble", obs_ifr, 96'd0);
    end
    repeat (6) step(0, 0, 64'h0, 1);

    // 5: redirect with stall and a same-cycle response
    step(1, 1, 64'h2000, 1);
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 64'h0, 1);
      chk("t5_bubble", obs_ifr, 96'd0);
    end
    step(0, 0, 64'h0, 1);
    chk("t5_first", obs_ifr, {32'h1357_BBDF, 64'h2004});

    // randomized traffic, including redirects near the top of the address space
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      logic [63:0] tgt;
      bit          rdir;
      rdir = ($urandom_range(99) < 4);
      if ($urandom_range(3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      else tgt = {$urandom, $urandom};
      step($urandom_range(99) < 25, rdir, tgt, $urandom_range(99) < 75);
    end

    // 6: asynchronous reset between edges mid-stream, then restart
    repeat (10) step(0, 0, 64'h0, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_if_cleared", IF_regs, 96'd0);
    chk("t6_req_cleared", {95'd0, imem_req_valid}, 96'd0);
    chk("t6_pc_cleared", {32'd0, imem_req_addr}, 96'd0);
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 64'h0, 1);
      if (k == 1) chk("t6_restart_addr", {32'd0, obs_addr}, 96'h0);
      if (k == 4) chk("t6_restart_pc4", {32'd0, obs_ifr[63:0]}, 96'h4);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
